// File: rtl/prescaled_event_counter_bank_pkg.sv
// rtl/prescaled_event_counter_bank_pkg.sv - shared constants and helpers for the event counter bank
package prescaled_event_counter_bank_pkg;

   localparam int MODE_WRAP   = 0;
   localparam int MODE_SAT    = 1;
   localparam int DIV_DEFAULT = 1;

   // Number of bits needed to address n items (n >= 2 gives at least 1)
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Lowest bit of channel ch inside a concatenated vector of w-bit slices
   function automatic int ch_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/prescaled_event_counter_bank_channel.sv
// rtl/prescaled_event_counter_bank_channel.sv - one prescaled event counter channel
module prescaled_counter_channel
   import prescaled_event_counter_bank_pkg::*;
#(
   parameter int CNT_W    = 64,
   parameter int PRE_W    = 8,
   parameter int SAT_MODE = MODE_WRAP,
   parameter int DIV_RST  = DIV_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             evt,
   input  logic             clr,
   input  logic             cfg_we,
   input  logic [PRE_W-1:0] cfg_div,
   output logic [CNT_W-1:0] count,
   output logic             tick,
   output logic             ovf
);

   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PRE_W-1:0] DIV_INIT = PRE_W'(DIV_RST);

   logic [PRE_W-1:0] div;
   logic [PRE_W-1:0] phase;
   logic [PRE_W-1:0] div_eff;
   logic             adv;
   logic             roll;
   logic             cnt_max;

   // Effective divisor (0 behaves as 1); clear and divisor writes both swallow the event
   always_comb begin
      div_eff = (div == '0) ? PRE_ONE : div;
      adv     = evt & ~clr & ~cfg_we;
      roll    = adv && (phase == (div_eff - PRE_ONE));
      cnt_max = &count;
   end

   // Divisor, prescaler phase, counter, sticky overflow and tick pulse
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div   <= DIV_INIT;
         phase <= '0;
         count <= '0;
         ovf   <= 1'b0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (cfg_we) begin
            div   <= cfg_div;
            phase <= '0;
         end
         if (clr) begin
            phase <= '0;
            count <= '0;
            ovf   <= 1'b0;
         end else if (adv) begin
            if (roll) begin
               phase <= '0;
               tick  <= 1'b1;
               if (cnt_max) begin
                  ovf <= 1'b1;
                  if (SAT_MODE != MODE_SAT) begin
                     count <= '0;
                  end
               end else begin
                  count <= count + CNT_ONE;
               end
            end else begin
               phase <= phase + PRE_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/prescaled_event_counter_bank.sv
// rtl/prescaled_event_counter_bank.sv - bank of NUM_CH prescaled event counters
module prescaled_event_counter_bank
   import prescaled_event_counter_bank_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 64,
   parameter int PRE_W    = 8,
   parameter int SAT_MODE = MODE_WRAP,
   parameter int DIV_RST  = DIV_DEFAULT,
   localparam int SEL_W   = clog2(NUM_CH)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    En,
   input  logic [SEL_W-1:0]        Slt,
   input  logic [NUM_CH-1:0]       Clr,
   input  logic                    Cfg_We,
   input  logic [SEL_W-1:0]        Cfg_Ch,
   input  logic [PRE_W-1:0]        Cfg_Div,
   output logic [NUM_CH*CNT_W-1:0] Count,
   output logic [NUM_CH-1:0]       Tick,
   output logic [NUM_CH-1:0]       Ovf
);

   logic [NUM_CH-1:0] evt_oh;
   logic [NUM_CH-1:0] cfg_oh;

   // One-hot decode of event select and config address; out-of-range codes match nothing
   always_comb begin
      evt_oh = '0;
      cfg_oh = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         evt_oh[i] = En && (Slt == SEL_W'(i));
         cfg_oh[i] = Cfg_We && (Cfg_Ch == SEL_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      prescaled_counter_channel #(
         .CNT_W    (CNT_W),
         .PRE_W    (PRE_W),
         .SAT_MODE (SAT_MODE),
         .DIV_RST  (DIV_RST)
      ) u_ch (
         .Clk     (Clk),
         .Reset   (Reset),
         .evt     (evt_oh[g]),
         .clr     (Clr[g]),
         .cfg_we  (cfg_oh[g]),
         .cfg_div (Cfg_Div),
         .count   (Count[ch_lsb(g, CNT_W) +: CNT_W]),
         .tick    (Tick[g]),
         .ovf     (Ovf[g])
      );
   end

endmodule

// File: tb/tb_prescaled_event_counter_bank.sv
// tb/tb_prescaled_event_counter_bank.sv - scoreboard bench for the prescaled event counter bank
module tb_prescaled_event_counter_bank;

   localparam int NCH  = 3;
   localparam int CW   = 4;
   localparam int PW   = 8;
   localparam int DRST = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic            Clk;
   logic            Reset;
   logic            En;
   logic [1:0]      Slt;
   logic [NCH-1:0]  Clr;
   logic            Cfg_We;
   logic [1:0]      Cfg_Ch;
   logic [PW-1:0]   Cfg_Div;
   logic [NCH*CW-1:0] count_w, count_s;
   logic [NCH-1:0]  tick_w, tick_s, ovf_w, ovf_s;

   prescaled_event_counter_bank #(
      .NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW), .SAT_MODE(0), .DIV_RST(DRST)
   ) u_wrap (
      .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr),
      .Cfg_We(Cfg_We), .Cfg_Ch(Cfg_Ch), .Cfg_Div(Cfg_Div),
      .Count(count_w), .Tick(tick_w), .Ovf(ovf_w)
   );

   prescaled_event_counter_bank #(
      .NUM_CH(NCH), .CNT_W(CW), .PRE_W(PW), .SAT_MODE(1), .DIV_RST(DRST)
   ) u_sat (
      .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr),
      .Cfg_We(Cfg_We), .Cfg_Ch(Cfg_Ch), .Cfg_Div(Cfg_Div),
      .Count(count_s), .Tick(tick_s), .Ovf(ovf_s)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [NCH*CW-1:0] cw;
      logic [NCH*CW-1:0] cs;
      logic [NCH-1:0]    tk;
      logic [NCH-1:0]    ov;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference state: increments since last clear, events since last roll/write/clear, divisor
   int         incs[NCH];
   int         evs[NCH];
   logic [PW-1:0] mdiv[NCH];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic [1:0] slt,
                       input logic [NCH-1:0] clr, input logic we,
                       input logic [1:0] cch, input logic [PW-1:0] cdiv);
      exp_t e;
      int   eff;
      @(negedge Clk);
      #1;
      Reset = rst; En = en; Slt = slt; Clr = clr;
      Cfg_We = we; Cfg_Ch = cch; Cfg_Div = cdiv;
      e = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rst) begin
            incs[i] = 0; evs[i] = 0; mdiv[i] = PW'(DRST);
         end else begin
            if (we && cch == 2'(i)) begin
               mdiv[i] = cdiv; evs[i] = 0;
            end
            if (clr[i]) begin
               incs[i] = 0; evs[i] = 0;
            end else if (en && slt == 2'(i) && !(we && cch == 2'(i))) begin
               eff = (mdiv[i] == 0) ? 1 : int'(mdiv[i]);
               evs[i]++;
               if (evs[i] % eff == 0) begin
                  evs[i] = 0;
                  incs[i]++;
                  e.tk[i] = 1'b1;
               end
            end
         end
         e.cw[i*CW +: CW] = CW'(incs[i] % (CMAX + 1));
         e.cs[i*CW +: CW] = CW'((incs[i] > CMAX) ? CMAX : incs[i]);
         e.ov[i] = (incs[i] > CMAX);
      end
      q.push_back(e);
   endtask

   task automatic ev(input int ch, input int n);
      for (int k = 0; k < n; k++) step(0, 1, 2'(ch), '0, 0, 0, 0);
   endtask

   task automatic cfg(input int ch, input int d);
      step(0, 0, 0, '0, 1, 2'(ch), PW'(d));
   endtask

   // monitor: compares DUT outputs with the oldest expectation every cycle
   always @(negedge Clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("count_wrap", 32'(count_w), 32'(mon_e.cw));
         chk("count_sat",  32'(count_s), 32'(mon_e.cs));
         chk("tick_wrap",  32'(tick_w),  32'(mon_e.tk));
         chk("tick_sat",   32'(tick_s),  32'(mon_e.tk));
         chk("ovf_wrap",   32'(ovf_w),   32'(mon_e.ov));
         chk("ovf_sat",    32'(ovf_s),   32'(mon_e.ov));
      end
   end

   initial begin
      Reset = 1'b1; En = 1'b0; Slt = '0; Clr = '0;
      Cfg_We = 1'b0; Cfg_Ch = '0; Cfg_Div = '0;

      step(1, 0, 0, '0, 0, 0, 0);
      step(1, 1, 0, '0, 0, 0, 0);
      @(posedge Clk); #1;
      chk("reset_count", 32'(count_w), 0);
      chk("reset_ovf", 32'(ovf_s), 0);

      // ch0 divisor 1, ten events
      cfg(0, 1);
      ev(0, 10);
      @(posedge Clk); #1;
      chk("ch0_ten", 32'(count_w[3:0]), 10);
      chk("others_zero", 32'(count_w[11:4]), 0);

      // ch1 divisor 4, nine events
      cfg(1, 4);
      ev(1, 9);
      @(posedge Clk); #1;
      chk("ch1_div4", 32'(count_w[7:4]), 2);

      // ch2 divisor 3, write-with-event restarts the phase
      cfg(2, 3);
      ev(2, 2);
      step(0, 1, 2, '0, 1, 2, 3);
      ev(2, 3);
      @(posedge Clk); #1;
      chk("ch2_restart", 32'(count_w[11:8]), 1);

      // ch0 through overflow: 17 increments total
      ev(0, 7);
      @(posedge Clk); #1;
      chk("wrap_count", 32'(count_w[3:0]), 1);
      chk("sat_count", 32'(count_s[3:0]), 15);
      chk("ovf0", 32'(ovf_w[0] & ovf_s[0]), 1);

      // clear with simultaneous event on ch1 at count 5
      cfg(1, 1);
      ev(1, 3);
      step(0, 1, 1, 3'b010, 0, 0, 0);
      @(posedge Clk); #1;
      chk("clr_count", 32'(count_w[7:4]), 0);
      chk("clr_tick", 32'(tick_w[1]), 0);
      ev(1, 4);
      @(posedge Clk); #1;
      chk("clr_div_kept", 32'(count_w[7:4]), 4);

      // out-of-range write, zero divisor, clear together with write
      step(0, 0, 0, '0, 1, 3, 7);
      cfg(2, 0);
      ev(2, 3);
      step(0, 1, 2, 3'b100, 1, 2, 2);
      ev(2, 3);
      ev(1, 2);

      // reset mid-stream with overflow set, then out-of-range selects
      step(1, 1, 0, '0, 0, 0, 0);
      @(posedge Clk); #1;
      chk("midreset_count", 32'(count_s), 0);
      chk("midreset_ovf", 32'(ovf_w), 0);
      ev(0, 4);
      ev(3, 5);
      @(posedge Clk); #1;
      chk("div_rst_ch0", 32'(count_w[3:0]), 2);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 15) == 0) ? NCH'($urandom_range(0, 7)) : '0,
              ($urandom_range(0, 9) == 0),
              2'($urandom_range(0, 3)),
              PW'($urandom_range(0, 4)));
      end

      repeat (3) @(negedge Clk);
      #2;
      chk("queue_drained", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
